// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Steps a frame index through the current animation at a prescaled rate. The
// result is the ani/frame pair consumed by the segment pattern decoder. A
// writable table holds the frame count of every animation. Playback modes are
// loop, ping-pong, one-shot and freeze. Animation switches are queued and
// applied on the next frame tick, so the decoder never sees a switch in the
// middle of a frame.
//
// Ports
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   ena        run enable; low freezes the prescaler and stepping
//   div        tick period minus one, counted in enabled cycles
//   mode       00 loop, 01 ping-pong, 10 one-shot, 11 freeze
//   ani_sel    requested animation
//   ani_req    capture ani_sel as the pending switch (last request wins)
//   cfg_we     frame-limit table write strobe
//   cfg_addr   table write address
//   cfg_limit  frame count written to table[cfg_addr]
//   ani        current animation (registered)
//   frame      current frame (registered)
//   step       one-cycle pulse when a frame/ani update lands
//   ani_ack    one-cycle pulse when a pending switch lands
//   done       one-shot has reached its last frame
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int ANI_W         = 6,
  parameter int FRAME_W       = 6,
  parameter int DIV_W         = 16,
  parameter int DEFAULT_LIMIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [DIV_W-1:0]   div,
  input  logic [1:0]         mode,
  input  logic [ANI_W-1:0]   ani_sel,
  input  logic               ani_req,
  input  logic               cfg_we,
  input  logic [ANI_W-1:0]   cfg_addr,
  input  logic [FRAME_W-1:0] cfg_limit,
  output logic [ANI_W-1:0]   ani,
  output logic [FRAME_W-1:0] frame,
  output logic               step,
  output logic               ani_ack,
  output logic               done
);

  localparam int ENTRIES = 1 << ANI_W;

  localparam logic [1:0] MODE_LOOP    = 2'b00;
  localparam logic [1:0] MODE_PING    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_FREEZE  = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // ---------------------------------------------------------------------------
  // Frame-limit table. The whole table must reload its default on reset, so it
  // is kept in flops rather than a RAM; each entry is its own small register.
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0] limit_mem [ENTRIES];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_limit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          limit_mem[gi] <= FRAME_W'(DEFAULT_LIMIT);
        end else if (cfg_we && (cfg_addr == ANI_W'(gi))) begin
          limit_mem[gi] <= cfg_limit;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]   cnt_reg,      cnt_next;
  logic [ANI_W-1:0]   ani_reg,      ani_next;
  logic [FRAME_W-1:0] frame_reg,    frame_next;
  dir_t               dir_reg,      dir_next;
  logic               done_reg,     done_next;
  logic               step_reg,     step_next;
  logic               ack_reg,      ack_next;
  logic [ANI_W-1:0]   pend_ani_reg, pend_ani_next;
  logic               pend_vld_reg, pend_vld_next;

  logic               tick;
  logic [FRAME_W-1:0] lim;
  logic [FRAME_W-1:0] last;
  logic               lim_short;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      ani_reg      <= '0;
      frame_reg    <= '0;
      dir_reg      <= DIR_UP;
      done_reg     <= 1'b0;
      step_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      pend_ani_reg <= '0;
      pend_vld_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      ani_reg      <= ani_next;
      frame_reg    <= frame_next;
      dir_reg      <= dir_next;
      done_reg     <= done_next;
      step_reg     <= step_next;
      ack_reg      <= ack_next;
      pend_ani_reg <= pend_ani_next;
      pend_vld_reg <= pend_vld_next;
    end
  end

  always_comb begin
    // Prescaler
    tick     = ena && (cnt_reg == div);
    cnt_next = cnt_reg;
    if (ena) begin
      cnt_next = tick ? '0 : cnt_reg + DIV_W'(1);
    end

    // The table read sees the pre-write value, so a write coinciding with a
    // tick only takes effect from the following tick. Limits 0 and 1 both
    // mean a single-frame animation.
    lim       = limit_mem[ani_reg];
    lim_short = (lim <= FRAME_W'(1));
    last      = lim_short ? '0 : lim - FRAME_W'(1);

    ani_next      = ani_reg;
    frame_next    = frame_reg;
    dir_next      = dir_reg;
    done_next     = done_reg;
    step_next     = 1'b0;
    ack_next      = 1'b0;
    pend_ani_next = pend_ani_reg;
    pend_vld_next = pend_vld_reg;

    if (ani_req) begin
      pend_ani_next = ani_sel;
      pend_vld_next = 1'b1;
    end

    if (tick) begin
      if (ani_req || pend_vld_reg) begin
        // A request in the tick cycle itself is applied right away.
        ani_next      = ani_req ? ani_sel : pend_ani_reg;
        frame_next    = '0;
        dir_next      = DIR_UP;
        done_next     = 1'b0;
        pend_vld_next = 1'b0;
        step_next     = 1'b1;
        ack_next      = 1'b1;
      end else begin
        if (mode != MODE_ONESHOT) begin
          done_next = 1'b0;
        end
        case (mode)
          MODE_LOOP: begin
            step_next  = 1'b1;
            frame_next = (frame_reg >= last) ? '0 : frame_reg + FRAME_W'(1);
          end
          MODE_PING: begin
            step_next = 1'b1;
            if (dir_reg == DIR_UP) begin
              if (frame_reg >= last) begin
                dir_next   = DIR_DOWN;
                frame_next = lim_short ? '0 : last - FRAME_W'(1);
              end else begin
                frame_next = frame_reg + FRAME_W'(1);
              end
            end else begin
              if (frame_reg == '0) begin
                dir_next   = DIR_UP;
                frame_next = lim_short ? '0 : FRAME_W'(1);
              end else begin
                frame_next = frame_reg - FRAME_W'(1);
              end
            end
          end
          MODE_ONESHOT: begin
            // done rises together with the arrival on the last frame.
            step_next  = 1'b1;
            frame_next = (frame_reg >= last) ? last : frame_reg + FRAME_W'(1);
            done_next  = (frame_next == last);
          end
          MODE_FREEZE: begin
            // Frame held, no step pulse.
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ani     = ani_reg;
  assign frame   = frame_reg;
  assign step    = step_reg;
  assign ani_ack = ack_reg;
  assign done    = done_reg;

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Programmable animation frame sequencer for the 7-segment display path. It steps a frame index through the current animation at a prescaled rate. It holds a writable per-animation frame-limit table and supports loop, ping-pong, one-shot and freeze playback. Animation switches are synchronised to frame boundaries. It sits between the animation-select logic and the segment pattern decoder, and drives the `ani`/`frame` pair that the decoder consumes.

## Interface
- `ANI_W`, 6, animation index width; the table has 2^ANI_W entries
- `FRAME_W`, 6, frame index and limit width; max limit 2^FRAME_W-1
- `DIV_W`, 16, prescaler divisor width
- `DEFAULT_LIMIT`, 2, table content after reset
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  run enable; low freezes the prescaler and stepping
- `div`  in  DIV_W  tick period minus one, in enabled cycles
- `mode`  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 freeze
- `ani_sel`  in  ANI_W  requested animation
- `ani_req`  in  1  capture `ani_sel` as the pending switch
- `cfg_we`  in  1  table write strobe
- `cfg_addr`  in  ANI_W  table write address
- `cfg_limit`  in  FRAME_W  frame count for `cfg_addr`
- `ani`  out  ANI_W  current animation
- `frame`  out  FRAME_W  current frame
- `step`  out  1  one-cycle pulse when the `frame`/`ani` update lands
- `ani_ack`  out  1  one-cycle pulse when a pending switch lands
- `done`  out  1  one-shot reached its last frame

## Operation
- Reset (async, `rst_n`=0) values:
  - `ani`=0, `frame`=0, `step`=0, `ani_ack`=0, `done`=0
  - direction=up, prescaler count=0, no pending switch
  - all table entries=DEFAULT_LIMIT
- Prescaler:
  - When `ena`=1: if count==`div`, then tick=1 and count←0; otherwise count+1.
  - When `ena`=0: count holds and there is no tick.
  - `div`=0 gives a tick every enabled cycle.
- Effective limit L = table[`ani`]. Values 0 and 1 are both treated as L=1 (frame stays 0).
- On a tick, with no switch landing:
  - loop: frame←frame+1. If frame≥L-1, frame←0.
  - ping-pong: step in the current direction.
    - Going up with frame≥L-1: direction←down, frame←L-2 (0 if L≤1).
    - Going down at 0: direction←up, frame←1 (0 if L≤1).
  - one-shot: frame+1 until frame≥L-1. Then frame←L-1 and done←1.
  - freeze: no change and no `step` pulse.
- Switch handshake:
  - `ani_req`=1 loads pending←`ani_sel` and sets the pending flag. The last request wins.
  - On the next tick with pending set: `ani`←pending, frame←0, direction←up, done←0, pending cleared, `ani_ack` pulses.
  - A switch overrides mode stepping, including freeze.
  - `ani_req` in the same cycle as a tick is applied at that tick.
- Table writes:
  - `cfg_we`=1 writes table[`cfg_addr`]←`cfg_limit` at the clock edge.
  - A write to the current `ani` is used from the next tick.
  - If frame is already ≥ the new L-1, that tick is treated as end-of-sequence per mode.
- Mode changes are sampled at each tick. Leaving one-shot clears `done` at the next tick.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Tick condition in cycle t: the new `frame`/`ani` is visible in t+1, and `step` is high during t+1 only.
- Tick spacing is `div`+1 enabled cycles.
- `ani_ack` coincides with the `step` pulse of the switching tick.
- Worst-case switch latency from `ani_req` is `div`+1 enabled cycles.
- `cfg_we` and a tick in the same cycle: the tick uses the old limit.
- `rst_n` asserted mid-sequence:
  - All state returns to reset values immediately.
  - The table reloads DEFAULT_LIMIT and the pending switch is dropped.

## Test plan
- Reset, `div`=0, mode=loop, `ena`=1 → `frame` 0,1,0,1… with `step` every cycle; `ani`=0.
- Write table[3]=5, then `ani_sel`=3 with `ani_req` and `div`=3 → `ani_ack` and `ani`=3, `frame`=0 within 4 cycles; then `frame` 1,2,3,4,0 every 4 cycles.
- L=4, ping-pong, `div`=0 → `frame` 0,1,2,3,2,1,0,1.
- L=3, one-shot → `frame` 0,1,2 then holds 2 with `done`=1. A switch clears `done` and sets `frame`=0.
- `ena` low for 10 cycles mid-count, and mode=freeze → no `step` and `frame` unchanged. A pending `ani_req` still lands at the next tick under freeze.
- With `frame`=7 and L=10, write L=4 to the current animation (loop) → the next tick gives `frame`=0. Then assert `rst_n`=0 mid-run → all outputs 0 and table[3] back to 2.
